// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Write-side controller for a WIDTH x HEIGHT RGB565 frame buffer. Two pixel
//   requesters share the single buffer write port through a valid/ready
//   handshake with round-robin fairness. A full-screen clear sequence fills
//   every location with a programmable colour. The write port is driven
//   straight from registers.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_clear_req             one-cycle pulse: start the full-screen fill
//   i_clear_color           fill colour, sampled together with i_clear_req
//   o_clear_busy            fill sequence in progress
//   o_clear_done            one-cycle pulse alongside the last fill write
//   i_reqN_valid/x/y/color  pixel request from requester N (N = 0, 1)
//   o_reqN_ready            combinational grant; transfer on valid && ready
//   o_fb_wr_en/addr/data    registered buffer write port
module fb_write_arbiter #(
   parameter int WIDTH  = 96,
   parameter int HEIGHT = 64,
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear_req,
   input  logic [DATA_W-1:0] i_clear_color,
   output logic              o_clear_busy,
   output logic              o_clear_done,
   input  logic              i_req0_valid,
   input  logic [6:0]        i_req0_x,
   input  logic [5:0]        i_req0_y,
   input  logic [DATA_W-1:0] i_req0_color,
   input  logic              i_req1_valid,
   input  logic [6:0]        i_req1_x,
   input  logic [5:0]        i_req1_y,
   input  logic [DATA_W-1:0] i_req1_color,
   output logic              o_req0_ready,
   output logic              o_req1_ready,
   output logic              o_fb_wr_en,
   output logic [ADDR_W-1:0] o_fb_wr_addr,
   output logic [DATA_W-1:0] o_fb_wr_data
);

   localparam int LAST = WIDTH * HEIGHT - 1;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_color;
   logic              r_last;      // 1: requester 1 was granted most recently
   logic              r_busy;
   logic              r_done;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;

   logic              w_open;
   logic              w_g0;
   logic              w_g1;
   logic [ADDR_W-1:0] w_addr0;
   logic [ADDR_W-1:0] w_addr1;
   logic              w_in0;
   logic              w_in1;
   logic              w_sel_in;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;

   // Grants open only in IDLE, outside reset and outside the clear-done cycle
   // (the cycle right after the last fill write must not carry a pixel write).
   // A clear request in the same cycle wins over pixel traffic.
   assign w_open = i_rst_n && (r_state == S_IDLE) && !r_done && !i_clear_req;
   assign w_g0   = w_open && i_req0_valid && (!i_req1_valid || r_last);
   assign w_g1   = w_open && i_req1_valid && (!i_req0_valid || !r_last);

   assign w_addr0 = ADDR_W'(i_req0_y) * ADDR_W'(WIDTH) + ADDR_W'(i_req0_x);
   assign w_addr1 = ADDR_W'(i_req1_y) * ADDR_W'(WIDTH) + ADDR_W'(i_req1_x);
   assign w_in0   = (int'(i_req0_x) < WIDTH) && (int'(i_req0_y) < HEIGHT);
   assign w_in1   = (int'(i_req1_x) < WIDTH) && (int'(i_req1_y) < HEIGHT);

   assign w_sel_in   = w_g1 ? w_in1   : w_in0;
   assign w_sel_addr = w_g1 ? w_addr1 : w_addr0;
   assign w_sel_data = w_g1 ? i_req1_color : i_req0_color;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_color   <= '0;
         r_last    <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_done  <= 1'b0;
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_clear_req && !r_done) begin
                  r_state <= S_CLEAR;
                  r_cnt   <= '0;
                  r_color <= i_clear_color;
                  r_busy  <= 1'b1;
               end else if (w_g0 || w_g1) begin
                  r_last <= w_g1;
                  // Out-of-range pixels complete the handshake but write nothing.
                  if (w_sel_in) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= w_sel_addr;
                     r_wr_data <= w_sel_data;
                  end
               end
            end
            S_CLEAR: begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_cnt;
               r_wr_data <= r_color;
               r_cnt     <= r_cnt + 1'b1;
               if (r_cnt == ADDR_W'(LAST)) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req0_ready = w_g0;
   assign o_req1_ready = w_g1;
   assign o_clear_busy = r_busy;
   assign o_clear_done = r_done;
   assign o_fb_wr_en   = r_wr_en;
   assign o_fb_wr_addr = r_wr_addr;
   assign o_fb_wr_data = r_wr_data;

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Write-side controller for the 96x64 RGB565 frame buffer. It shares the buffer's single write port between two pixel requesters, such as the sort-bar renderer and the text/overlay renderer, using a valid/ready handshake with round-robin fairness. It also runs a full-screen clear sequence that fills all 6144 locations with a programmable colour. It converts (x, y) coordinates to linear buffer addresses and drives the buffer's wr_en/wr_addr/wr_data directly from registers.

## Interface
- WIDTH, 96, screen width in pixels
- HEIGHT, 64, screen height in pixels
- ADDR_W, 13, buffer address width
- DATA_W, 16, pixel width (RGB565)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- clear_req  in  1  single-cycle pulse; start full-screen fill
- clear_color  in  DATA_W  fill colour, sampled with clear_req
- clear_busy  out  1  high while the fill sequence runs
- clear_done  out  1  one-cycle pulse coincident with the last fill write
- req0_valid / req1_valid  in  1  requester has a pixel
- req0_x / req1_x  in  7  pixel column
- req0_y / req1_y  in  6  pixel row
- req0_color / req1_color  in  DATA_W  pixel colour
- req0_ready / req1_ready  out  1  combinational grant; transfer occurs when valid && ready at an edge
- fb_wr_en  out  1  buffer write enable (registered)
- fb_wr_addr  out  ADDR_W  buffer write address (registered)
- fb_wr_data  out  DATA_W  buffer write data (registered)

## Operation
- States: IDLE (arbitrating requesters) and CLEAR (fill). Reset puts the block in IDLE.
- IDLE, clear_req=1:
  - Latch clear_color, reset the fill counter to 0, move to CLEAR.
  - Both readys are 0 that cycle; clear has priority over pixel requests.
- IDLE, no clear_req: arbitration.
  - Only one valid: that requester gets ready=1.
  - Both valid: grant goes to the requester not granted most recently. last_grant resets to 1, so req0 wins the first contention.
  - last_grant updates only on an actual transfer.
- Transfer: the edge registers fb_wr_en=1, fb_wr_addr = y*WIDTH + x (13-bit; max 63*96+95 = 6143), fb_wr_data = colour.
- Out-of-range coordinates (x >= WIDTH or y >= HEIGHT): the handshake completes (ready honoured) but fb_wr_en stays 0 and nothing is written.
- Cycles with no transfer: fb_wr_en=0; fb_wr_addr/fb_wr_data hold their previous values.
- CLEAR: every cycle register fb_wr_en=1, fb_wr_addr=counter, fb_wr_data=latched colour, then increment the counter.
  - On the write of address WIDTH*HEIGHT-1 (6143): assert clear_done for that cycle, drop clear_busy, return to IDLE.
  - Both readys are held at 0 throughout CLEAR.
  - clear_req pulses during CLEAR are ignored. The fill is not restarted and the colour is not relatched.
- Requesters must hold valid, x, y and colour stable until ready. The block never drops a valid request without a handshake.

## Timing
- Reset values (rst_n=0 at an edge): state IDLE; counter 0; last_grant=1; fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0; clear_busy=0, clear_done=0. Readys are 0 during reset.
- Pixel latency: a handshake at edge T produces the write outputs valid after edge T. The buffer stores the pixel at edge T+1.
- Throughput: one pixel per cycle sustained in IDLE. With both requesters continuously valid, grants strictly alternate.
- Clear timing, for clear_req sampled at edge T:
  - clear_busy is 1 after T.
  - Address k is presented after edge T+1+k.
  - Address 6143 is presented after edge T+6144, together with clear_done=1.
  - After edge T+6145: clear_busy=0, clear_done=0, fb_wr_en=0. Readys may assert in that cycle.
  - Total fill is 6144 write cycles.
- Reset mid-clear: the next edge aborts the fill, all outputs go to reset values, and no further writes occur.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req0_valid=1 -> req0_ready=0, fb_wr_en=0, fb_wr_addr=0, clear_busy=0 throughout.
- Single pixel: req0 (x=5, y=2, 16'hF800) -> one-cycle fb_wr_en with addr 197, data F800. req0_ready high exactly one cycle.
- Contention: both valid continuously with distinct colours for 6 cycles -> grants go req0, req1, req0, req1, req0, req1. Addresses match each requester.
- Bounds: req1 (x=95, y=63) -> addr 6143. Then req1 (x=96, y=0) -> ready handshake occurs, fb_wr_en stays 0.
- Clear: clear_req with colour 16'h001F while req0 is valid:
  - Exactly 6144 consecutive writes, addresses 0..6143, all data 001F.
  - clear_done on the addr-6143 cycle only.
  - req0_ready=0 until after the fill, then req0 is served.
  - A second clear_req at fill cycle 100 (colour FFFF) has no effect.
- Reset mid-clear: assert rst_n=0 at fill cycle 1000 -> writes stop next cycle, clear_busy=0. A fresh clear then restarts from address 0.
